ssd_scan_controller: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It takes four BCD digits plus per-digit blank and decimal-point flags and cycles through the digits at a fixed refresh rate. For each digit it drives the active-low segment bus and the active-low digit-enable lines, with a ghosting guard interval between digits. New values are double-buffered and only become visible on a frame boundary, so a display never shows a mix of old and new values. It sits between the board-level counters/FSMs and the FPGA seven-segment pins.

---
 rtl/ssd_scan_controller.sv | 100 ++++++++++
 tb/tb_ssd_scan_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_controller.sv
// Multiplexed scan controller for a 4-digit common-anode seven-segment display,
// with frame-aligned double buffering of the displayed digits.
package ssd_scan_pkg;
   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  blank;
      logic [3:0]  dp;
   } disp_buf_t;
endpackage

module ssd_scan_controller
   import ssd_scan_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD       = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  blank,
   input  logic [3:0]  dp,
   input  logic        load,
   output logic [7:0]  display,
   output logic [3:0]  ctrl,
   output logic        frame_done
);

   localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   disp_buf_t     pending;
   disp_buf_t     active;
   disp_buf_t     incoming;
   logic          pend_valid;
   logic          boundary;
   logic          slot_end;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b0111000;
      endcase
   endfunction

   assign incoming = '{digits: digits, blank: blank, dp: dp};
   assign slot_end = (cnt == CNT_LAST);
   assign boundary = slot_end && (idx == 2'd3);

   // Scan position, buffers and frame pulse; a load on the boundary bypasses pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         pend_valid <= 1'b0;
         frame_done <= 1'b0;
         pending    <= '{digits: 16'h0000, blank: 4'h0, dp: 4'h0};
         active     <= '{digits: 16'h0000, blank: 4'hF, dp: 4'h0};
      end else begin
         frame_done <= boundary;
         if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (load && boundary) begin
            active     <= incoming;
            pend_valid <= 1'b0;
         end else if (load) begin
            pending    <= incoming;
            pend_valid <= 1'b1;
         end else if (boundary && pend_valid) begin
            active     <= pending;
            pend_valid <= 1'b0;
         end
      end
   end

   // Pin drive derived from the registered scan state.
   always_comb begin
      ctrl    = 4'b1111;
      display = 8'hFF;
      if (!((cnt < CW'(GUARD)) || active.blank[idx])) begin
         ctrl    = ~(4'b0001 << idx);
         display = {seg_decode(4'(active.digits >> {idx, 2'b00})), ~active.dp[idx]};
      end
   end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller: a frame-level reference model predicts
// every cycle's pin state; a separate monitor compares against the DUT.
module tb_ssd_scan_controller;

   localparam int RD    = 8;
   localparam int GD    = 2;
   localparam int FRAME = 4 * RD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digits = '0;
   logic [3:0]  blank = '0;
   logic [3:0]  dp = '0;
   logic        load = 1'b0;
   logic [7:0]  display;
   logic [3:0]  ctrl;
   logic        frame_done;

   ssd_scan_controller #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
      .clk(clk), .rst(rst), .digits(digits), .blank(blank), .dp(dp),
      .load(load), .display(display), .ctrl(ctrl), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          stamp;
      logic [15:0] d;
      logic [3:0]  b;
      logic [3:0]  p;
   } ld_t;

   typedef struct {
      int         n;
      logic [3:0] ctrl;
      logic [7:0] disp;
      logic       fd;
   } exp_t;

   ld_t  lq[$];
   exp_t sb[$];
   int   n = 0;
   int   compared = 0;
   int   mismatched = 0;

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b0111000;
      endcase
   endfunction

   // Frame f shows the last load taken before the frame's first cycle.
   function automatic exp_t model(input int t);
      exp_t        e;
      int          f, s, c;
      logic [15:0] d;
      logic [3:0]  b, p;
      f = t / FRAME;
      s = (t / RD) % 4;
      c = t % RD;
      d = 16'h0000; b = 4'hF; p = 4'h0;
      for (int i = lq.size() - 1; i >= 0; i--) begin
         if (lq[i].stamp < f * FRAME) begin
            d = lq[i].d; b = lq[i].b; p = lq[i].p;
            break;
         end
      end
      e.n    = t;
      e.fd   = (t > 0) && (t % FRAME == 0);
      e.ctrl = 4'b1111;
      e.disp = 8'hFF;
      if (c >= GD && !b[s]) begin
         for (int i = 0; i < 4; i++) e.ctrl[i] = (i != s);
         e.disp = {seg_of(int'((d >> (4 * s)) & 16'hF)), !p[s]};
      end
      return e;
   endfunction

   task automatic cycle(input bit ld, input logic [15:0] d, input logic [3:0] b,
                        input logic [3:0] p);
      ld_t r;
      @(negedge clk);
      rst = 1'b0;
      load = ld; digits = d; blank = b; dp = p;
      if (ld) begin
         r.stamp = n; r.d = d; r.b = b; r.p = p;
         lq.push_back(r);
      end
      sb.push_back(model(n));
      n++;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0);
   endtask

   task automatic do_reset(input int hold);
      exp_t e;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         rst = 1'b1;
         load = 1'b0;
         lq.delete();
         n = 0;
         e = model(0);
         sb.push_back(e);
      end
   endtask

   task automatic wait_pos(input int slot, input int c);
      while (!(((n / RD) % 4) == slot && (n % RD) == c)) idle(1);
   endtask

   // Monitor: compares DUT pins to the oldest expectation once per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if (ctrl !== e.ctrl || display !== e.disp || frame_done !== e.fd) begin
               mismatched++;
               $display("FAIL pins n=%0d: got ctrl=%b display=%b frame_done=%b, want ctrl=%b display=%b frame_done=%b",
                        e.n, ctrl, display, frame_done, e.ctrl, e.disp, e.fd);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(3);
      idle(5);
      cycle(1'b1, 16'h1234, 4'h0, 4'h0);
      idle(3 * FRAME);
      cycle(1'b1, 16'hF0A0, 4'h0, 4'b0100);
      idle(2 * FRAME);
      cycle(1'b1, 16'h4321, 4'b1010, 4'b0001);
      idle(2 * FRAME);
      wait_pos(0, 3);
      cycle(1'b1, 16'h5678, 4'h0, 4'h0);
      idle(5);
      cycle(1'b1, 16'h9ABC, 4'h0, 4'h0);
      idle(2 * FRAME);
      wait_pos(3, RD - 1);
      cycle(1'b1, 16'h8765, 4'h0, 4'b1000);
      idle(FRAME + 4);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(9) == 0)
            cycle(1'b1, 16'($urandom), ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0,
                  4'($urandom));
         else
            cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
      end
      cycle(1'b1, 16'h2468, 4'h0, 4'h0);
      idle(FRAME);
      wait_pos(2, 4);
      do_reset(2);
      #1;
      if (ctrl !== 4'b1111) begin
         mismatched++;
         $display("FAIL reset ctrl: got %b want 1111", ctrl);
      end
      if (display !== 8'hFF) begin
         mismatched++;
         $display("FAIL reset display: got %b want 11111111", display);
      end
      if (frame_done !== 1'b0) begin
         mismatched++;
         $display("FAIL reset frame_done: got %b want 0", frame_done);
      end
      idle(2 * FRAME + 3);
      cycle(1'b1, 16'h1357, 4'h0, 4'h2);
      idle(2 * FRAME);
      @(negedge clk);
      #2;
      if (compared == 0) $display("FAIL no comparisons performed");
      if (mismatched != 0) $display("FAIL %0d mismatches", mismatched);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
